idli_alu_m: RTL and testbench
=============================

Name: idli_alu_m

Overview:
- Nibble-serial 16-bit ALU, directly downstream of the general register file.
- Consumes the B/C read nibbles, LSB nibble first, one nibble per cycle over 4 cycles.
- Produces the result nibble in the same cycle so the register file write port (A data) can shift it into the destination register in lock-step.
- Carries carry/borrow and zero state across nibbles and publishes flags when an operation completes.

Parameters:
- none (datapath fixed: 4-bit nibble, 16-bit operand, 4 nibbles per operation)

Ports:
- i_alu_gck  input  1  clock; the same gated clock as the register file
- i_alu_rst  input  1  reset, asynchronous, active-high
- i_alu_start  input  1  marks nibble 0 of a new operation
- i_alu_op  input  3  operation, sampled with i_alu_start: 0 ADD, 1 SUB, 2 AND, 3 ANDN (lhs & ~rhs), 4 OR, 5 XOR, 6 INC (lhs+1), 7 PASS (rhs)
- i_alu_lhs  input  4  operand nibble from register file B read port
- i_alu_rhs  input  4  operand nibble from register file C read port
- o_alu_out  output  4  result nibble, combinational, same cycle as operands
- o_alu_out_vld  output  1  high on each of the 4 nibble cycles of an accepted operation; drives the A write-valid
- o_alu_done  output  1  combinational, high on nibble 3 of an accepted operation
- o_alu_carry  output  1  registered carry flag, updated when an operation completes
- o_alu_zero  output  1  registered zero flag, updated when an operation completes

Behaviour:
- State: IDLE / BUSY, 2-bit nibble counter cnt, latched op, carry flop, zero-accumulate flop.
- Reset (async, any time) forces:
  - state=IDLE, cnt=0, carry flop=0, zacc=0
  - o_alu_carry=0, o_alu_zero=0
  - o_alu_out_vld=0, o_alu_done=0, o_alu_out=0
- Reset mid-operation aborts it: no done, flags keep reset values.
- Start acceptance:
  - Accepted when IDLE.
  - Accepted when BUSY with cnt==3 (back-to-back; the new nibble 0 follows old nibble 3 with no bubble).
  - Ignored when BUSY with cnt 0..2: the current operation continues unchanged.
- Effective op and carry-in per nibble:
  - Nibble 0 uses i_alu_op directly; nibbles 1..3 use the op latched at acceptance.
  - Carry-in at nibble 0: SUB and INC use 1, all other ops use 0.
  - Carry-in at nibbles 1..3: the carry flop.
- Arithmetic (5-bit sum per nibble; bit 4 goes to the carry flop):
  - ADD: lhs + rhs + cin
  - SUB: lhs + ~rhs + cin; carry=1 means no borrow
  - INC: lhs + 0 + cin
- Logic ops and PASS: out is bitwise, carry-out is 0.
- Cycle sequence: the accepted start cycle is nibble 0 (cnt=0), then cnt=1,2,3.
  - o_alu_out_vld=1 on all four nibble cycles.
  - o_alu_done=1 at cnt==3; without a new start, state returns to IDLE on the next edge.
- Zero flag:
  - zacc accumulates OR of the out nibbles; it restarts at nibble 0 and ignores the old accumulation.
  - On the done-cycle edge: o_alu_zero <= ~(zacc | |out), and o_alu_carry <= the nibble-3 carry-out.
- Flags hold until the next completed operation. A back-to-back start still updates the flags from the finishing operation.
- In IDLE:
  - o_alu_out=0, o_alu_out_vld=0.
  - Operand inputs are ignored; the carry flop is not updated.
- Latency: result nibble k on cycle k (zero cycles); flags visible the cycle after done.
- i_alu_op changes during nibbles 1..3 have no effect.

Test Plan:
- ADD, lhs 0x00FF, rhs 0x0001, start at cycle 0 -> out nibbles 0,0,1,0 (0x0100); vld on 4 cycles; done on cycle 3; then carry=0, zero=0.
- ADD 0xFFFF + 0x0001 -> out 0x0000; carry=1, zero=1.
- SUB 0x1234 - 0x1234 -> out 0x0000, carry=1, zero=1.
- SUB 0x0000 - 0x0001 -> out 0xFFFF, carry=0, zero=0.
- Back-to-back operations:
  - INC 0x000F, then start on cycle 3 with XOR 0xA5A5 ^ 0xFFFF -> 0x0010 then 0x5A5A with no bubble.
  - Flags after the first done: carry=0, zero=0.
  - A start pulsed at cnt=1 of the XOR is ignored and i_alu_op changes are ignored.
- Reset mid-operation:
  - Assert i_alu_rst at cnt=2 of an ADD -> all outputs 0 immediately (async); no done; flags remain 0.
  - The next start after release runs a clean 4-nibble operation with carry-in 0.

Source files
------------

// File: rtl/idli_alu_m.sv
// ---------------------------------------------------------------------------
// idli_alu_m : nibble-serial 16-bit ALU, LSB nibble first, 4 cycles per op.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idli_alu_m (
    input  logic       i_alu_gck,
    input  logic       i_alu_rst,
    input  logic       i_alu_start,
    input  logic [2:0] i_alu_op,
    input  logic [3:0] i_alu_lhs,
    input  logic [3:0] i_alu_rhs,
    output logic [3:0] o_alu_out,
    output logic       o_alu_out_vld,
    output logic       o_alu_done,
    output logic       o_alu_carry,
    output logic       o_alu_zero
);

    localparam logic [2:0] C_OP_ADD  = 3'd0;
    localparam logic [2:0] C_OP_SUB  = 3'd1;
    localparam logic [2:0] C_OP_AND  = 3'd2;
    localparam logic [2:0] C_OP_ANDN = 3'd3;
    localparam logic [2:0] C_OP_OR   = 3'd4;
    localparam logic [2:0] C_OP_XOR  = 3'd5;
    localparam logic [2:0] C_OP_INC  = 3'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_op;
    logic       r_carry;
    logic       r_zacc;
    logic       r_flag_c;
    logic       r_flag_z;

    logic       w_start_idle;
    logic       w_start_b2b;
    logic       w_active;
    logic       w_first;
    logic [2:0] w_op;
    logic       w_cin;
    logic [4:0] w_sum;
    logic [3:0] w_out;
    logic       w_done;
    logic       w_zacc_nxt;

    assign w_start_idle = (r_state == IDLE) && i_alu_start;
    // A start on the last nibble queues the next op; its nibble 0 follows at cnt 0.
    assign w_start_b2b  = (r_state == BUSY) && (r_cnt == 2'd3) && i_alu_start;
    assign w_active     = w_start_idle || (r_state == BUSY);
    assign w_first      = w_start_idle || ((r_state == BUSY) && (r_cnt == 2'd0));
    assign w_op         = w_start_idle ? i_alu_op : r_op;
    assign w_cin        = w_first ? ((w_op == C_OP_SUB) || (w_op == C_OP_INC)) : r_carry;

    always_comb begin
        w_sum = 5'd0;
        case (w_op)
            C_OP_ADD:  w_sum = {1'b0, i_alu_lhs} + {1'b0, i_alu_rhs} + {4'd0, w_cin};
            C_OP_SUB:  w_sum = {1'b0, i_alu_lhs} + {1'b0, ~i_alu_rhs} + {4'd0, w_cin};
            C_OP_INC:  w_sum = {1'b0, i_alu_lhs} + {4'd0, w_cin};
            C_OP_AND:  w_sum = {1'b0, i_alu_lhs & i_alu_rhs};
            C_OP_ANDN: w_sum = {1'b0, i_alu_lhs & ~i_alu_rhs};
            C_OP_OR:   w_sum = {1'b0, i_alu_lhs | i_alu_rhs};
            C_OP_XOR:  w_sum = {1'b0, i_alu_lhs ^ i_alu_rhs};
            default:   w_sum = {1'b0, i_alu_rhs};
        endcase
    end

    assign w_out      = w_active ? w_sum[3:0] : 4'd0;
    assign w_done     = (r_state == BUSY) && (r_cnt == 2'd3);
    assign w_zacc_nxt = (w_first ? 1'b0 : r_zacc) | (|w_out);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_alu_start) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = 2'd1;
                end
            end
            BUSY: begin
                if (r_cnt == 2'd3) begin
                    w_state_nxt = i_alu_start ? BUSY : IDLE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
        if (i_alu_rst) begin
            r_state  <= IDLE;
            r_cnt    <= 2'd0;
            r_op     <= 3'd0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start_idle || w_start_b2b) begin
                r_op <= i_alu_op;
            end
            if (w_active) begin
                r_carry <= w_sum[4];
                r_zacc  <= w_zacc_nxt;
            end
            if (w_done) begin
                r_flag_c <= w_sum[4];
                r_flag_z <= ~w_zacc_nxt;
            end
        end
    end

    assign o_alu_out     = w_out;
    assign o_alu_out_vld = w_active;
    assign o_alu_done    = w_done;
    assign o_alu_carry   = r_flag_c;
    assign o_alu_zero    = r_flag_z;

endmodule

`default_nettype wire

// File: tb/tb_idli_alu_m.sv
// ---------------------------------------------------------------------------
// tb_idli_alu_m : scoreboard bench for the nibble-serial ALU.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_idli_alu_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] lhs;
    logic [3:0] rhs;
    logic [3:0] out;
    logic       out_vld;
    logic       done;
    logic       carry;
    logic       zero;

    idli_alu_m dut (
        .i_alu_gck     (clk),
        .i_alu_rst     (rst),
        .i_alu_start   (start),
        .i_alu_op      (op),
        .i_alu_lhs     (lhs),
        .i_alu_rhs     (rhs),
        .o_alu_out     (out),
        .o_alu_out_vld (out_vld),
        .o_alu_done    (done),
        .o_alu_carry   (carry),
        .o_alu_zero    (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic       last;
    } exp_t;

    typedef struct {
        logic c;
        logic z;
    } flg_t;

    exp_t exp_q[$];
    flg_t flg_q[$];
    int   checks = 0;
    int   fails  = 0;
    logic exp_c  = 1'b0;
    logic exp_z  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Whole-word reference: 16-bit arithmetic, then split into nibbles.
    function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        logic        c;
        exp_t        e;
        flg_t        f;
        c = 1'b0;
        case (o)
            3'd0: {c, res} = {1'b0, a} + {1'b0, b};
            3'd1: begin res = a - b; c = (a >= b); end
            3'd2: res = a & b;
            3'd3: res = a & ~b;
            3'd4: res = a | b;
            3'd5: res = a ^ b;
            3'd6: {c, res} = {1'b0, a} + 17'd1;
            default: res = b;
        endcase
        for (int k = 0; k < 4; k++) begin
            e.nib  = res[4*k +: 4];
            e.last = (k == 3);
            exp_q.push_back(e);
        end
        f.c = c;
        f.z = (res == 16'd0);
        flg_q.push_back(f);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the 4 nibbles of one op; optionally queues the next op on nibble 3.
    task automatic drive_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                            input bit with_start, input bit chain, input logic [2:0] nop,
                            input bit noise);
        model(o, a, b);
        for (int k = 0; k < 4; k++) begin
            lhs   = a[4*k +: 4];
            rhs   = b[4*k +: 4];
            start = (k == 0 && with_start) || (k == 3 && chain) ||
                    (noise && (k == 1 || k == 2) && ($urandom_range(1) == 1));
            if (k == 0)               op = o;
            else if (k == 3 && chain) op = nop;
            else                      op = 3'($urandom);
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            op    = 3'($urandom);
            lhs   = 4'($urandom);
            rhs   = 4'($urandom);
            next_cycle();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        flg_t f;
        if (rst) begin
            exp_c = 1'b0;
            exp_z = 1'b0;
        end else begin
            check("carry_flag", 16'(carry), 16'(exp_c));
            check("zero_flag", 16'(zero), 16'(exp_z));
            check("out_vld", 16'(out_vld), 16'(exp_q.size() != 0));
            if (out_vld && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_nibble", 16'(out), 16'(e.nib));
                check("done", 16'(done), 16'(e.last));
                if (e.last) begin
                    f     = flg_q.pop_front();
                    exp_c = f.c;
                    exp_z = f.z;
                end
            end else if (!out_vld) begin
                check("idle_out", 16'(out), 16'd0);
                check("idle_done", 16'(done), 16'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] cur_o;
        logic [2:0] next_o;
        bit         prev_chain;
        bit         ch;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        lhs   = 4'd0;
        rhs   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 16'(out), 16'd0);
        check("rst_vld", 16'(out_vld), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_carry", 16'(carry), 16'd0);
        check("rst_zero", 16'(zero), 16'd0);
        rst = 1'b0;
        next_cycle();

        drive_op(3'd0, 16'h00FF, 16'h0001, 1, 0, 3'd0, 0);
        idle(1);
        drive_op(3'd0, 16'hFFFF, 16'h0001, 1, 0, 3'd0, 0);
        idle(1);
        drive_op(3'd1, 16'h1234, 16'h1234, 1, 0, 3'd0, 0);
        idle(1);
        drive_op(3'd1, 16'h0000, 16'h0001, 1, 0, 3'd0, 0);
        idle(1);
        drive_op(3'd6, 16'h000F, 16'h0000, 1, 1, 3'd5, 0);
        drive_op(3'd5, 16'hA5A5, 16'hFFFF, 0, 0, 3'd0, 1);
        idle(2);

        // Abort an ADD on its third nibble with an asynchronous reset.
        model(3'd0, 16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 2; k++) begin
            start = (k == 0);
            op    = 3'd0;
            lhs   = 4'hF;
            rhs   = 4'hF;
            next_cycle();
        end
        start = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        flg_q.delete();
        #1;
        check("abort_out", 16'(out), 16'd0);
        check("abort_vld", 16'(out_vld), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        check("abort_carry", 16'(carry), 16'd0);
        check("abort_zero", 16'(zero), 16'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        drive_op(3'd0, 16'h0001, 16'h0001, 1, 0, 3'd0, 0);
        idle(1);

        prev_chain = 1'b0;
        cur_o      = 3'($urandom);
        for (int i = 0; i < 60; i++) begin
            next_o = 3'($urandom);
            ch     = (i < 59) && ($urandom_range(1) == 1);
            drive_op(cur_o, 16'($urandom), 16'($urandom), !prev_chain, ch, next_o, 1);
            if (!ch) idle($urandom_range(0, 2));
            prev_chain = ch;
            cur_o      = next_o;
        end
        idle(3);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
